ifu_fetch: RTL and testbench

- Instruction fetch unit for the RV64 NPC core.
- Keeps the architectural fetch PC and issues one 32-bit instruction read at a time over a req/gnt/rvld memory port.
- Holds each returned instruction in a registered output slot with a valid/ready handshake toward the decode stage.
- Handles redirects from the branch/trap logic, including squashing an in-flight response.

---
 rtl/ifu_fetch_pkg.sv | 20 ++
 rtl/ifu_fetch.sv | 102 ++++++++++
 tb/tb_ifu_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared fetch-stage types and constants for the RV64 NPC core.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } fetch_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with a registered decode slot and redirect squash.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_vld,
    input  logic [63:0] redirect_pc,
    input  logic        IDU_rdy,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvld,
    input  logic [31:0] mem_rdata,
    output logic        IFU_vld,
    output logic [63:0] IFU_inst,
    output logic [63:0] IFU_pc
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         vld_q, vld_d;
    logic [63:0]  inst_q, inst_d;
    logic [63:0]  ipc_q, ipc_d;
    logic [63:0]  target;

    assign target = redirect_pc & ~64'h3;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // Memory only samples the address on a grant, so retargeting here is safe.
                if (redirect_vld) pc_d = target;
                if (mem_gnt) state_d = redirect_vld ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect_vld) begin
                    pc_d    = target;
                    state_d = mem_rvld ? REQ : DROP;
                end else if (mem_rvld) begin
                    inst_d  = {32'b0, mem_rdata};
                    ipc_d   = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + 64'd4;
                    state_d = HOLD;
                end
            end
            DROP: begin
                if (redirect_vld) pc_d = target;
                if (mem_rvld) state_d = REQ;
            end
            HOLD: begin
                if (redirect_vld) begin
                    pc_d    = target;
                    vld_d   = 1'b0;
                    state_d = REQ;
                end else if (IDU_rdy) begin
                    vld_d   = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            inst_q  <= 64'd0;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end

    assign mem_req  = (state_q == REQ);
    assign mem_addr = pc_q;
    assign IFU_vld  = vld_q;
    assign IFU_inst = inst_q;
    assign IFU_pc   = ipc_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table, reset corner sequence and randomized run against a transaction model.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [63:0] C_RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect_vld;
    logic [63:0] redirect_pc;
    logic        IDU_rdy;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvld;
    logic [31:0] mem_rdata;
    logic        IFU_vld;
    logic [63:0] IFU_inst;
    logic [63:0] IFU_pc;

    ifu_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .IDU_rdy(IDU_rdy),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
        .IFU_vld(IFU_vld), .IFU_inst(IFU_inst), .IFU_pc(IFU_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rd;
        logic [63:0] rpc;
        logic        rdy;
        logic        gnt;
        logic        rvld;
        logic [31:0] rdata;
    } stim_t;

    typedef struct {
        stim_t       in;
        logic        ereq;
        logic [63:0] eaddr;
        logic        evld;
        logic [63:0] einst;
        logic [63:0] epc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: a pending request, an in-flight read (possibly stale), and a slot.
    logic        m_started, m_inflight, m_stale, m_slot;
    logic [63:0] m_pc, m_inst, m_ipc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic stim_t st(input logic r, input logic rd, input logic [63:0] rpc,
                                 input logic rdy, input logic gnt, input logic rvld,
                                 input logic [31:0] rdata);
        stim_t s;
        s.rst_n = r; s.rd = rd; s.rpc = rpc; s.rdy = rdy;
        s.gnt = gnt; s.rvld = rvld; s.rdata = rdata;
        return s;
    endfunction

    function automatic vec_t mk(input stim_t s, input logic ereq, input logic [63:0] eaddr,
                                input logic evld, input logic [63:0] einst, input logic [63:0] epc);
        vec_t v;
        v.in = s; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.einst = einst; v.epc = epc;
        return v;
    endfunction

    task automatic model_step();
        logic [63:0] tgt;
        tgt = redirect_pc & ~64'h3;
        if (!rst_n) begin
            m_started = 1'b0; m_inflight = 1'b0; m_stale = 1'b0; m_slot = 1'b0;
            m_pc = C_RESET_PC; m_inst = 64'd0; m_ipc = C_RESET_PC;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_slot) begin
            if (redirect_vld) begin
                m_slot = 1'b0; m_pc = tgt;
            end else if (IDU_rdy) begin
                m_slot = 1'b0;
            end
        end else if (m_inflight) begin
            if (mem_rvld) begin
                if (!m_stale && !redirect_vld) begin
                    m_inst = {32'd0, mem_rdata};
                    m_ipc  = m_pc;
                    m_slot = 1'b1;
                    m_pc   = m_pc + 64'd4;
                end
                m_inflight = 1'b0;
                m_stale    = 1'b0;
            end else if (redirect_vld) begin
                m_stale = 1'b1;
            end
            if (redirect_vld) m_pc = tgt;
        end else begin
            if (redirect_vld) m_pc = tgt;
            if (mem_gnt) begin
                m_inflight = 1'b1;
                m_stale    = redirect_vld;
            end
        end
    endtask

    // Called at a negedge: apply stimulus, let the edge happen, then return at the next negedge.
    task automatic drive(input stim_t s);
        rst_n = s.rst_n; redirect_vld = s.rd; redirect_pc = s.rpc; IDU_rdy = s.rdy;
        mem_gnt = s.gnt; mem_rvld = s.rvld; mem_rdata = s.rdata;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_mem_req"},  {63'd0, mem_req}, {63'd0, m_started && !m_inflight && !m_slot});
        chk({tag, "_mem_addr"}, mem_addr, m_pc);
        chk({tag, "_ifu_vld"},  {63'd0, IFU_vld}, {63'd0, m_slot});
        chk({tag, "_ifu_inst"}, IFU_inst, m_inst);
        chk({tag, "_ifu_pc"},   IFU_pc, m_ipc);
    endtask

    vec_t  tbl[$];
    stim_t nil;

    initial begin
        nil = st(1, 0, 64'd0, 0, 0, 0, 32'd0);
        m_started = 0; m_inflight = 0; m_stale = 0; m_slot = 0;
        m_pc = C_RESET_PC; m_inst = 0; m_ipc = C_RESET_PC;
        rst_n = 0; redirect_vld = 0; redirect_pc = 0; IDU_rdy = 0;
        mem_gnt = 0; mem_rvld = 0; mem_rdata = 0;
        @(negedge clk);
        drive(st(0, 0, 64'd0, 0, 0, 0, 32'd0));
        drive(st(0, 0, 64'd0, 0, 0, 0, 32'd0));

        // c0..c23: basic fetch, held slot, WAIT redirect, coincident redirect, ungranted retarget.
        tbl.push_back(mk(nil,                                            0, 64'h8000_0000, 0, 64'h0, 64'h8000_0000));
        tbl.push_back(mk(st(1,0,64'd0,0,1,0,32'd0),                     1, 64'h8000_0000, 0, 64'h0, 64'h8000_0000));
        tbl.push_back(mk(st(1,0,64'd0,0,0,1,32'h0010_0093),             0, 64'h8000_0000, 0, 64'h0, 64'h8000_0000));
        tbl.push_back(mk(st(1,0,64'd0,1,0,0,32'd0),                     0, 64'h8000_0004, 1, 64'h0010_0093, 64'h8000_0000));
        tbl.push_back(mk(st(1,0,64'd0,0,1,0,32'd0),                     1, 64'h8000_0004, 0, 64'h0010_0093, 64'h8000_0000));
        tbl.push_back(mk(st(1,0,64'd0,0,0,1,INST_NOP),                  0, 64'h8000_0004, 0, 64'h0010_0093, 64'h8000_0000));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(nil,                                        0, 64'h8000_0008, 1, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,1,0,0,32'd0),                     0, 64'h8000_0008, 1, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,0,1,0,32'd0),                     1, 64'h8000_0008, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,1,64'h8000_0100,0,0,0,32'd0),             0, 64'h8000_0008, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,0,0,1,32'hdead_beef),             0, 64'h8000_0100, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,0,1,0,32'd0),                     1, 64'h8000_0100, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,1,64'h8000_0203,0,0,1,32'hcafe_f00d),     0, 64'h8000_0100, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(nil,                                            1, 64'h8000_0200, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,1,64'h8000_0400,0,0,0,32'd0),             1, 64'h8000_0200, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(nil,                                            1, 64'h8000_0400, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(nil,                                            1, 64'h8000_0400, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,0,1,0,32'd0),                     1, 64'h8000_0400, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,0,0,1,32'h00a0_0513),             0, 64'h8000_0400, 0, 64'h13, 64'h8000_0004));
        tbl.push_back(mk(st(1,0,64'd0,1,0,0,32'd0),                     0, 64'h8000_0404, 1, 64'h00a0_0513, 64'h8000_0400));
        tbl.push_back(mk(nil,                                            1, 64'h8000_0404, 0, 64'h00a0_0513, 64'h8000_0400));

        foreach (tbl[i]) begin
            chk($sformatf("vec%0d_mem_req", i),  {63'd0, mem_req}, {63'd0, tbl[i].ereq});
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].eaddr);
            chk($sformatf("vec%0d_ifu_vld", i),  {63'd0, IFU_vld}, {63'd0, tbl[i].evld});
            chk($sformatf("vec%0d_ifu_inst", i), IFU_inst, tbl[i].einst);
            chk($sformatf("vec%0d_ifu_pc", i),   IFU_pc, tbl[i].epc);
            drive(tbl[i].in);
        end

        // Reset while waiting for data, then a stale response right after release.
        drive(st(1, 0, 64'd0, 0, 1, 0, 32'd0));
        chk("rst_wait_state_req", {63'd0, mem_req}, 64'd0);
        drive(st(0, 0, 64'd0, 0, 0, 0, 32'd0));
        chk("rst_idle_req",  {63'd0, mem_req}, 64'd0);
        chk("rst_idle_vld",  {63'd0, IFU_vld}, 64'd0);
        chk("rst_idle_pc",   IFU_pc, C_RESET_PC);
        chk("rst_idle_inst", IFU_inst, 64'd0);
        drive(st(1, 0, 64'd0, 0, 0, 1, 32'h1234_5678));
        chk("rst_first_req",  {63'd0, mem_req}, 64'd1);
        chk("rst_first_addr", mem_addr, C_RESET_PC);
        chk("rst_stale_vld",  {63'd0, IFU_vld}, 64'd0);
        drive(st(1, 0, 64'd0, 0, 0, 1, 32'h1234_5678));
        chk("rst_stale2_vld", {63'd0, IFU_vld}, 64'd0);
        chk("rst_stale2_req", {63'd0, mem_req}, 64'd1);

        // Randomized traffic, including spurious responses and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            stim_t s;
            check_model("rand");
            s.rst_n = ($urandom_range(0, 199) != 0);
            s.rd    = ($urandom_range(0, 9) == 0);
            s.rpc   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) s.rpc[63:32] = 32'hffff_ffff;
            s.rdy   = $urandom_range(0, 1) == 1;
            s.gnt   = $urandom_range(0, 2) != 0;
            s.rvld  = $urandom_range(0, 9) < 4;
            s.rdata = $urandom;
            drive(s);
        end
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
